modular_multiplier: RTL and testbench

MODULAR_MULTIPLIER -- requirements
Module: modular_multiplier

---
 rtl/modular_multiplier_pkg.sv | 20 ++
 rtl/mul64x64_pipe.sv | 16 +
 rtl/modular_multiplier.sv | 123 ++++++++++++
 tb/tb_modular_multiplier.sv | 166 ++++++++++++++++
 4 files changed

// File: rtl/modular_multiplier_pkg.sv
// Shared constants for the pipelined Barrett modular multiplier.
package modular_multiplier_pkg;

    localparam int unsigned W  = 64;      // operand / result width
    localparam int unsigned W2 = 2 * W;   // full product width

    localparam logic [W-1:0] P_DEFAULT       = 64'd18434813901432784897;
    localparam int unsigned  LATENCY_DEFAULT = 6;

    // floor(2^128 / p); needs 65 bits because p lies between 2^63 and 2^64.
    function automatic logic [W:0] barrett_mu(input logic [W-1:0] p);
        logic [W2:0] num;
        num     = '0;
        num[W2] = 1'b1;
        return (W+1)'(num / {{(W+1){1'b0}}, p});
    endfunction

    localparam logic [W:0] MU_DEFAULT = barrett_mu(P_DEFAULT);

endpackage

// File: rtl/mul64x64_pipe.sv
// Registered 64x64 -> 128 unsigned multiplier (one cycle latency, no reset).
module mul64x64_pipe
    import modular_multiplier_pkg::*;
(
    input  logic          clk_i,
    input  logic [W-1:0]  a_i,
    input  logic [W-1:0]  b_i,
    output logic [W2-1:0] p_o
);

    // Product register; datapath only, so no reset.
    always_ff @(posedge clk_i) begin
        p_o <= {{W{1'b0}}, a_i} * {{W{1'b0}}, b_i};
    end

endmodule

// File: rtl/modular_multiplier.sv
// Fully pipelined (A*B) mod P using Barrett reduction; one result per cycle.
// Register timeline for a pair sampled at edge N:
//   N   operands          N+1 x = A*B          N+2 low part of (x>>63)*MU
//   N+3 q estimate        N+4 q*P              N+5 r = x - q*P, first fix-up
//   N+6 second fix-up into mul_out, mul_done raised
module modular_multiplier
    import modular_multiplier_pkg::*;
#(
    parameter logic [W-1:0] P       = P_DEFAULT,
    parameter int unsigned  LATENCY = LATENCY_DEFAULT  // datapath is built for 6
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic [W-1:0] mul_ina,
    input  logic [W-1:0] mul_inb,
    input  logic         mul_start,
    output logic [W-1:0] mul_out,
    output logic         mul_done
);

    localparam logic [W:0]  MU = barrett_mu(P);
    localparam int unsigned MW = W2 + 3;

    logic [W-1:0]   a_q, b_q;
    logic [W2-1:0]  x2, m3, qp5;
    logic [W2-1:0]  x3_q;
    logic [W+1:0]   x4_q, x5_q;
    logic [W:0]     corr, q4_d, q4_q;
    logic [MW-1:0]  mprod;
    logic           qh5_q;
    logic [W+1:0]   qp_lo, r_full;
    logic [W:0]     r6_d, r6_q;
    logic [W-1:0]   out_d;
    logic [LATENCY-1:0] v_q;
    logic           unused_bits;

    // Operand capture every cycle; validity travels separately in v_q.
    always_ff @(posedge clk) begin
        a_q <= mul_ina;
        b_q <= mul_inb;
    end

    mul64x64_pipe u_mul_ab (
        .clk_i (clk),
        .a_i   (a_q),
        .b_i   (b_q),
        .p_o   (x2)
    );

    // Only the low 64 bits of floor(x/2^63) and MU go through the multiplier;
    // the top bits of both are folded in afterwards as shifted additions.
    mul64x64_pipe u_mul_mu (
        .clk_i (clk),
        .a_i   (x2[W2-2:W-1]),
        .b_i   (MU[W-1:0]),
        .p_o   (m3)
    );

    // Keep x alongside the MU product so the cross terms can be added.
    always_ff @(posedge clk) begin
        x3_q <= x2;
    end

    // Complete the 65x65 product and shift down by 65 to get q (up to 65 bits).
    always_comb begin
        corr  = (x3_q[W2-1] ? {1'b0, MU[W-1:0]} : '0)
              + (MU[W] ? {1'b0, x3_q[W2-2:W-1]} : '0);
        mprod = MW'(m3) + (MW'(corr) << W) + (MW'(x3_q[W2-1] & MU[W]) << W2);
        q4_d  = mprod[W2+1:W+1];
    end

    // Register q; x is only needed modulo 2^66 from here on.
    always_ff @(posedge clk) begin
        q4_q <= q4_d;
        x4_q <= x3_q[W+1:0];
    end

    mul64x64_pipe u_mul_qp (
        .clk_i (clk),
        .a_i   (q4_q[W-1:0]),
        .b_i   (P),
        .p_o   (qp5)
    );

    // Track the top bit of q and x in step with the q*P product.
    always_ff @(posedge clk) begin
        qh5_q <= q4_q[W];
        x5_q  <= x4_q;
    end

    // r = x - q*P is < 3P < 2^66, so 66-bit wraparound arithmetic is exact.
    always_comb begin
        qp_lo  = qp5[W+1:0] + (qh5_q ? {P[1:0], {W{1'b0}}} : '0);
        r_full = x5_q - qp_lo;
        r6_d   = (r_full >= {2'b00, P}) ? (W+1)'(r_full - {2'b00, P}) : r_full[W:0];
    end

    // Remainder after the first fix-up (< 2P).
    always_ff @(posedge clk) begin
        r6_q <= r6_d;
    end

    // Second fix-up brings the result into [0, P-1].
    always_comb begin
        out_d = (r6_q >= {1'b0, P}) ? W'(r6_q - {1'b0, P}) : r6_q[W-1:0];
    end

    // Valid shift chain and output register, cleared asynchronously.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            v_q      <= '0;
            mul_done <= 1'b0;
            mul_out  <= '0;
        end else begin
            v_q      <= {v_q[LATENCY-2:0], mul_start};
            mul_done <= v_q[LATENCY-1];
            mul_out  <= out_d;
        end
    end

    assign unused_bits = ^{mprod[MW-1], mprod[W:0], qp5[W2-1:W+2]};

endmodule

// File: tb/tb_modular_multiplier.sv
// Self-checking bench: random and directed pairs against a plain-arithmetic model.
module tb_modular_multiplier;
    import modular_multiplier_pkg::*;

    localparam int unsigned LAT  = LATENCY_DEFAULT;
    localparam logic [63:0] PM   = P_DEFAULT;
    localparam logic [63:0] MAXV = 64'hFFFF_FFFF_FFFF_FFFF;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [63:0] mul_ina = '0;
    logic [63:0] mul_inb = '0;
    logic        mul_start = 1'b0;
    logic [63:0] mul_out;
    logic        mul_done;

    always #5 clk = ~clk;

    modular_multiplier dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .mul_ina   (mul_ina),
        .mul_inb   (mul_inb),
        .mul_start (mul_start),
        .mul_out   (mul_out),
        .mul_done  (mul_done)
    );

    typedef struct {
        logic        v;
        logic [63:0] exp;
    } ent_t;

    ent_t        sb[$];
    int unsigned n_checks = 0;
    int unsigned n_pass   = 0;
    int unsigned n_fail   = 0;
    int unsigned cyc      = 0;

    function automatic logic [63:0] ref_mod(input logic [63:0] a, input logic [63:0] b);
        logic [127:0] prod;
        prod = {64'd0, a} * {64'd0, b};
        return 64'(prod % {64'd0, PM});
    endfunction

    function automatic logic [63:0] rand64();
        return {$urandom(), $urandom()};
    endfunction

    function automatic logic [63:0] pick();
        case ($urandom_range(0, 9))
            0:       return 64'd0;
            1:       return PM;
            2:       return PM + 64'd1;
            3:       return MAXV;
            4:       return PM - 64'd1;
            default: return rand64();
        endcase
    endfunction

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        assert (obs === exp) n_pass++;
        else begin
            n_fail++;
            $error("FAIL %s cycle %0d: observed 0x%h, expected 0x%h", tag, cyc, obs, exp);
        end
    endtask

    // Empty pipeline after reset: the next LAT edges must show no done.
    task automatic fill_sb();
        sb.delete();
        for (int i = 0; i < LAT; i++) sb.push_back('{v: 1'b0, exp: 64'd0});
    endtask

    // One clock: drive inputs, record what the edge sampled, check #1 later.
    task automatic step(input logic s, input logic [63:0] a, input logic [63:0] b,
                        input logic [63:0] gold, input logic use_gold);
        ent_t e;
        mul_start = s;
        mul_ina   = a;
        mul_inb   = b;
        @(posedge clk);
        cyc++;
        if (rst_n) sb.push_back('{v: s, exp: (use_gold ? gold : ref_mod(a, b))});
        #1;
        if (!rst_n) begin
            chk("rst_done", {63'd0, mul_done}, 64'd0);
            chk("rst_out", mul_out, 64'd0);
        end else if (sb.size() > LAT) begin
            e = sb.pop_front();
            chk("done", {63'd0, mul_done}, {63'd0, e.v});
            if (e.v) chk("out", mul_out, e.exp);
        end
    endtask

    task automatic issue(input logic [63:0] a, input logic [63:0] b);
        step(1'b1, a, b, 64'd0, 1'b0);
    endtask

    task automatic issue_gold(input logic [63:0] a, input logic [63:0] b,
                              input logic [63:0] g);
        step(1'b1, a, b, g, 1'b1);
    endtask

    // Idle cycles with junk operands: they must not produce done pulses.
    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(1'b0, rand64(), rand64(), 64'd0, 1'b0);
    endtask

    initial begin
        // Reset state
        for (int i = 0; i < 3; i++) step(1'b1, rand64(), rand64(), 64'd0, 1'b0);
        rst_n = 1'b1;
        fill_sb();
        idle(4);

        // Basic products on consecutive cycles
        issue_gold(64'd0, 64'd1, 64'd0);
        issue_gold(64'd2, 64'd3, 64'd6);
        issue_gold(64'd4, 64'd5, 64'd20);
        idle(LAT + 2);

        // Modulus boundaries
        issue_gold(PM, 64'd1, 64'd0);
        issue_gold(PM + 64'd1, 64'd1, 64'd1);
        issue(MAXV, MAXV);
        issue(64'd0, MAXV);
        issue(PM - 64'd1, PM - 64'd1);
        issue(MAXV, PM);
        idle(LAT + 2);

        // Large operands with known results
        issue_gold(64'd13901706437927406777, 64'd15700958295376441594,
                   64'h1e0bf2d51992b7dc);
        issue_gold(64'd1835666423505824111, 64'd4408257175847215637,
                   64'hcbfe78b99f4fb18c);
        idle(LAT + 2);

        // 37 back-to-back pairs then idle
        for (int i = 0; i < 37; i++) issue(rand64(), rand64());
        idle(LAT + 2);

        // Reset with operations in flight and results currently on the output
        for (int i = 0; i < 8; i++) issue(rand64() | 64'd1, rand64() | 64'd1);
        rst_n = 1'b0;
        #1;
        chk("arst_out", mul_out, 64'd0);
        chk("arst_done", {63'd0, mul_done}, 64'd0);
        step(1'b1, rand64(), rand64(), 64'd0, 1'b0);
        step(1'b1, rand64(), rand64(), 64'd0, 1'b0);
        rst_n = 1'b1;
        fill_sb();
        idle(LAT + 4);

        // Random regression with mul_start toggled randomly
        for (int i = 0; i < 3000; i++) begin
            step(1'($urandom_range(0, 1)), pick(), pick(), 64'd0, 1'b0);
        end
        idle(LAT + 2);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
